// File: rtl/mcycle_wb_queue.sv
// Write-back queue behind the multi-cycle mul/div unit: buffers results in order and
// drains them into the register-file port whenever the main pipeline is not writing.
module mcycle_wb_queue #(
    parameter int width = 32,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       MPushIn,
    input  logic [3:0]                 MCycleWA3,
    input  logic [width-1:0]           MResult,
    input  logic                       RegWriteW,
    input  logic [3:0]                 WA3W,
    input  logic [width-1:0]           ResultW,
    output logic                       WE3,
    output logic [3:0]                 A3,
    output logic [width-1:0]           WD3,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Count,
    output logic [15:0]                PendingMask,
    output logic                       Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DEPTH-1:0]   live_q;
    logic [3:0]         wa3_q  [DEPTH];
    logic [width-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CW-1:0]      count_q;
    logic               overflow_q;

    logic               head_live;
    logic               pop;
    logic               push;
    logic               drop;

    assign Empty     = (count_q == '0);
    assign Full      = (count_q == CW'(DEPTH));
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign head_live = live_q[head_q];

    // A killed head is discarded even while the main pipeline owns the write port.
    assign pop  = !Empty && (!RegWriteW || !head_live);
    assign push = MPushIn && (!Full || pop);
    assign drop = MPushIn && Full && !pop;

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (RegWriteW) begin
            WE3 = 1'b1;
            A3  = WA3W;
            WD3 = ResultW;
        end else if (!Empty && head_live) begin
            WE3 = 1'b1;
            A3  = wa3_q[head_q];
            WD3 = data_q[head_q];
        end
    end

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) PendingMask[wa3_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Squash first, so a same-cycle push to the same register below stays live.
            for (int i = 0; i < DEPTH; i++) begin
                if (RegWriteW && live_q[i] && (wa3_q[i] == WA3W)) live_q[i] <= 1'b0;
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            if (push) begin
                live_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + 1'b1;
            end
            if (drop) overflow_q <= 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            wa3_q[tail_q]  <= MCycleWA3;
            data_q[tail_q] <= MResult;
        end
    end

endmodule

// File: tb/tb_mcycle_wb_queue.sv
// Directed bench for mcycle_wb_queue with a reference queue model checked every cycle.
module tb_mcycle_wb_queue;

    localparam int W = 32;
    localparam int D = 4;

    logic          CLK;
    logic          Reset;
    logic          MPushIn;
    logic [3:0]    MCycleWA3;
    logic [W-1:0]  MResult;
    logic          RegWriteW;
    logic [3:0]    WA3W;
    logic [W-1:0]  ResultW;
    logic          WE3;
    logic [3:0]    A3;
    logic [W-1:0]  WD3;
    logic          Full;
    logic          Empty;
    logic [2:0]    Count;
    logic [15:0]   PendingMask;
    logic          Overflow;

    mcycle_wb_queue #(.width(W), .DEPTH(D)) dut (
        .CLK(CLK), .Reset(Reset), .MPushIn(MPushIn), .MCycleWA3(MCycleWA3),
        .MResult(MResult), .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .WE3(WE3), .A3(A3), .WD3(WD3), .Full(Full), .Empty(Empty), .Count(Count),
        .PendingMask(PendingMask), .Overflow(Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         live;
        logic [3:0]   wa3;
        logic [W-1:0] data;
    } ent_t;

    ent_t mdl[$];
    logic mov;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic        we;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [15:0] pm;
        we = 1'b0; a = '0; wd = '0; pm = '0;
        if (RegWriteW) begin
            we = 1'b1; a = WA3W; wd = ResultW;
        end else if (mdl.size() > 0 && mdl[0].live) begin
            we = 1'b1; a = mdl[0].wa3; wd = mdl[0].data;
        end
        foreach (mdl[i]) if (mdl[i].live) pm[mdl[i].wa3] = 1'b1;
        chk("m_we3",   32'(WE3),         32'(we));
        chk("m_a3",    32'(A3),          32'(a));
        chk("m_wd3",   WD3,              wd);
        chk("m_count", 32'(Count),       32'(mdl.size()));
        chk("m_empty", 32'(Empty),       32'(mdl.size() == 0));
        chk("m_full",  32'(Full),        32'(mdl.size() == D));
        chk("m_pend",  32'(PendingMask), 32'(pm));
        chk("m_ovf",   32'(Overflow),    32'(mov));
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        logic emp, ful, hl, pop, push;
        emp  = (mdl.size() == 0);
        ful  = (mdl.size() == D);
        hl   = !emp && mdl[0].live;
        pop  = !emp && (!RegWriteW || !hl);
        push = MPushIn && (!ful || pop);
        if (MPushIn && ful && !pop) mov = 1'b1;
        if (RegWriteW) begin
            foreach (mdl[i]) if (mdl[i].wa3 == WA3W) mdl[i].live = 1'b0;
        end
        if (pop) void'(mdl.pop_front());
        if (push) mdl.push_back({1'b1, MCycleWA3, MResult});
    endtask

    task automatic drive(input logic p, input logic [3:0] pwa, input logic [31:0] pd,
                         input logic rw, input logic [3:0] wwa, input logic [31:0] wd);
        MPushIn = p; MCycleWA3 = pwa; MResult = pd;
        RegWriteW = rw; WA3W = wwa; ResultW = wd;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    endtask

    initial begin
        mov = 1'b0;
        Reset = 1'b1;
        MPushIn = 1'b0; MCycleWA3 = '0; MResult = '0;
        RegWriteW = 1'b0; WA3W = '0; ResultW = '0;
        #1;
        chk("rst_we3",   32'(WE3),         0);
        chk("rst_a3",    32'(A3),          0);
        chk("rst_wd3",   WD3,              0);
        chk("rst_empty", 32'(Empty),       1);
        chk("rst_full",  32'(Full),        0);
        chk("rst_count", 32'(Count),       0);
        chk("rst_pend",  32'(PendingMask), 0);
        chk("rst_ovf",   32'(Overflow),    0);
        @(negedge CLK);
        Reset = 1'b0;

        // Single push, written the following cycle.
        drive(1'b1, 4'd3, 32'h2A, 1'b0, 4'd0, 32'h0);
        tick();
        idle();
        chk("t1_we3",  32'(WE3), 1);
        chk("t1_a3",   32'(A3),  3);
        chk("t1_wd3",  WD3,      32'h2A);
        chk("t1_pend", 32'(PendingMask), 32'h0008);
        tick();
        idle();
        chk("t1_empty", 32'(Empty), 1);
        chk("t1_pend0", 32'(PendingMask), 0);
        tick();

        // Pipeline owns the port for three cycles.
        drive(1'b1, 4'd5, 32'h11, 1'b1, 4'd7, 32'h99);
        chk("t2_we3", 32'(WE3), 1);
        chk("t2_a3",  32'(A3),  7);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h99);
            chk("t2_wd3",   WD3, 32'h99);
            chk("t2_count", 32'(Count), 1);
            tick();
        end
        idle();
        chk("t2_a3q",  32'(A3), 5);
        chk("t2_wd3q", WD3, 32'h11);
        tick();

        // Fill, overflow, then push concurrent with pop at Full.
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 4'(r), 32'h100 + 32'(r), 1'b1, 4'd9, 32'hAB);
            tick();
        end
        drive(1'b1, 4'd8, 32'h108, 1'b1, 4'd9, 32'hAB);
        tick();
        idle();
        chk("t3_full",  32'(Full), 1);
        chk("t3_ovf",   32'(Overflow), 1);
        chk("t3_count", 32'(Count), 4);
        chk("t3_pend",  32'(PendingMask), 32'h001E);
        drive(1'b1, 4'd10, 32'hC0, 1'b0, 4'd0, 32'h0);
        tick();
        idle();
        chk("t3_count_pp", 32'(Count), 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
        end
        chk("t3_drained", 32'(Empty), 1);

        // WAW squash: killed head pops silently under a pipeline write.
        drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h70);
        tick();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h77);
        chk("t4_pend_pre", 32'(PendingMask), 32'h0040);
        tick();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h88);
        chk("t4_pend", 32'(PendingMask), 0);
        chk("t4_count", 32'(Count), 1);
        tick();
        idle();
        chk("t4_empty", 32'(Empty), 1);
        chk("t4_we3",   32'(WE3), 0);
        tick();

        // Same-cycle push to the register being written stays live.
        drive(1'b1, 4'd2, 32'h55, 1'b1, 4'd2, 32'h22);
        tick();
        idle();
        chk("t5_we3", 32'(WE3), 1);
        chk("t5_a3",  32'(A3),  2);
        chk("t5_wd3", WD3,      32'h55);
        tick();
        idle();
        tick();

        // Asynchronous reset while draining.
        for (int r = 11; r <= 13; r++) begin
            drive(1'b1, 4'(r), 32'h200 + 32'(r), 1'b1, 4'd0, 32'h1);
            tick();
        end
        idle();
        tick();
        idle();
        #1 Reset = 1'b1;
        #1;
        mdl.delete();
        mov = 1'b0;
        chk("t6_we3",   32'(WE3), 0);
        chk("t6_count", 32'(Count), 0);
        chk("t6_empty", 32'(Empty), 1);
        chk("t6_ovf",   32'(Overflow), 0);
        chk("t6_pend",  32'(PendingMask), 0);
        #1 Reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t6_nowr", 32'(WE3), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcycle_wb_queue.md
Name: mcycle_wb_queue

Overview:
- Write-back stage directly downstream of the multi-cycle multiply/divide unit.
- Captures each completed (destination register, result) pair when the unit pulses its push strobe and buffers it in a small in-order queue.
- Drains the queue into the register-file write port in cycles where the main pipeline is not writing back.
- Exports a per-register pending mask for hazard detection, and squashes queued results made stale by a younger pipeline write to the same register.

Parameters:
- width, 32, data width of results and register-file write data.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- MPushIn  in  1  one-cycle push strobe from multi-cycle unit.
- MCycleWA3  in  4  destination register of pushed result.
- MResult  in  width  pushed result value.
- RegWriteW  in  1  main pipeline write-back enable this cycle.
- WA3W  in  4  main pipeline destination register.
- ResultW  in  width  main pipeline write data.
- WE3  out  1  register-file write enable.
- A3  out  4  register-file write address.
- WD3  out  width  register-file write data.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Count  out  $clog2(DEPTH)+1  occupied entries, including killed ones.
- PendingMask  out  16  bit r set iff a live (not killed) entry targets register r.
- Overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Storage: circular buffer of DEPTH entries {live, wa3[3:0], data[width-1:0]}, plus head/tail pointers that wrap modulo DEPTH, plus Count.
- Reset (async, any time, including mid-drain): pointers=0, Count=0, all live=0, Overflow=0.
  - Outputs immediately: WE3=0, A3=0, WD3=0, Empty=1, Full=0, PendingMask=0.
- Write port is combinational, priority fixed:
  - RegWriteW=1: WE3=1, A3=WA3W, WD3=ResultW. The queue never writes that cycle.
  - Else, Empty=0 and head live: WE3=1, A3=head.wa3, WD3=head.data.
  - Else: WE3=0, A3=0, WD3=0.
- Pop on a clock edge when Empty=0 and either:
  - RegWriteW=0 (head written if live, discarded if killed); or
  - head killed (a killed head is discarded even while the pipeline writes).
- Push (tail <= {1, MCycleWA3, MResult}) when MPushIn=1 and (Full=0 or pop this cycle).
  - MPushIn=1 with Full=1 and no pop: entry dropped, Overflow<=1, state otherwise unchanged.
- Simultaneous push and pop: Count unchanged, both pointers advance. Legal at Full and at Count=1.
- Latency: no bypass. A result pushed at edge N is written at the earliest in the cycle after edge N (committed at edge N+1), provided the queue was empty and RegWriteW=0.
- Ordering: strictly FIFO; no reordering among queue entries.
- Squash (WAW): on each edge with RegWriteW=1, every live entry with wa3==WA3W gets live<=0.
  - A same-cycle push with MCycleWA3==WA3W is NOT killed; the queued result is younger.
- Pop, push and squash all evaluate from pre-edge state in the same cycle.
- PendingMask: OR of one-hot(wa3) over live entries; combinational from registered state.
- Count, Full and Empty are registered-state derived; no glitching on MPushIn.

Test Plan:
- Reset, then MPushIn=1, WA3=3, MResult=0x0000_002A, RegWriteW=0 → next cycle WE3=1, A3=3, WD3=0x2A, PendingMask=0x0008; following cycle Empty=1, PendingMask=0.
- Push WA3=5, data 0x11 while RegWriteW=1 (WA3W=7, ResultW=0x99) for 3 cycles → WE3=1/A3=7/WD3=0x99 each cycle, Count=1 held; first cycle with RegWriteW=0 writes A3=5, WD3=0x11.
- Fill 4 entries (regs 1..4) with RegWriteW held 1, then a 5th push → Full=1, Overflow=1, Count=4, PendingMask=0x001E. Then hold RegWriteW=0 and push a 5th entry in the same cycle as a pop → accepted, Count stays 4.
- Queue holds live entry WA3=6, then RegWriteW=1, WA3W=6 → next cycle PendingMask bit6=0; that entry pops without WE3 assertion, even while RegWriteW is still 1.
- Same-cycle RegWriteW=1, WA3W=2 and MPushIn=1, MCycleWA3=2, data 0x55 → entry stays live; later written A3=2, WD3=0x55.
- Assert Reset asynchronously with 3 entries queued mid-drain → WE3=0, Count=0, Empty=1, Overflow=0 before the next edge; no further writes after release.
